// File: rtl/decoder_arbiter.sv
// Shares one decoder among N_REQ requesters: grant 1 cycle after req, enable held HOLD_CYCLES, then a RELEASE gap.
// Requests are level-held until done; losers wait. Optional round-robin via DECODER_ARB_RR_EN (default fixed priority).
module decoder_arbiter #(
  parameter int IN_WIDTH    = 9,
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*IN_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic                      dec_enable,
  output logic [IN_WIDTH-1:0]       dec_addr,
  output logic                      busy
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW   = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, RELEASE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IDXW-1:0] w_q;
  logic [IDXW-1:0] win;
  logic [N_REQ-1:0] win_oh;

`ifdef DECODER_ARB_RR_EN
  logic [IDXW-1:0] ptr;

  // Search starts just after the last served requester.
  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        win   = IDXW'(idx);
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) win = IDXW'(i);
    end
  end
`endif

  always_comb begin
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      w_q        <= '0;
      grant      <= '0;
      done       <= '0;
      dec_enable <= 1'b0;
      dec_addr   <= '0;
      busy       <= 1'b0;
`ifdef DECODER_ARB_RR_EN
      ptr        <= IDXW'(N_REQ - 1);
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            w_q        <= win;
            dec_addr   <= req_addr[int'(win)*IN_WIDTH +: IN_WIDTH];
            grant      <= win_oh;
            dec_enable <= 1'b1;
            busy       <= 1'b1;
            cnt        <= CW'(HOLD_CYCLES - 1);
            state      <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (cnt == '0) begin
            dec_enable <= 1'b0;
            grant      <= '0;
            done       <= grant;
            state      <= RELEASE;
`ifdef DECODER_ARB_RR_EN
            ptr        <= w_q;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RELEASE: begin
          done     <= '0;
          dec_addr <= '0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_arbiter.sv
// Scoreboard bench for decoder_arbiter: main instance with HOLD_CYCLES=2, second instance with HOLD_CYCLES=1 for gap checks.
module tb_decoder_arbiter;
  localparam int W = 9;
  localparam int N = 4;
  localparam int H = 2;

  typedef struct {
    int idx;
    int addr;
    bit chk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_addr = '0;
  logic [N-1:0] grant, done;
  logic         dec_enable, busy;
  logic [W-1:0] dec_addr;

  logic [N-1:0] req1 = '0;
  logic [N*W-1:0] req_addr1 = '0;
  logic [N-1:0] grant1, done1;
  logic         dec_enable1, busy1;
  logic [W-1:0] dec_addr1;

  int ncmp = 0;
  int nfail = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  decoder_arbiter #(.IN_WIDTH(W), .N_REQ(N), .HOLD_CYCLES(H)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
    .grant(grant), .done(done), .dec_enable(dec_enable),
    .dec_addr(dec_addr), .busy(busy)
  );

  decoder_arbiter #(.IN_WIDTH(W), .N_REQ(N), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_addr(req_addr1),
    .grant(grant1), .done(done1), .dec_enable(dec_enable1),
    .dec_addr(dec_addr1), .busy(busy1)
  );

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Main-instance monitor: pops one expected access per rising dec_enable.
  int   cyc = 0, last_start = 0, en_len = 0;
  bit   in_acc = 0, prev_en = 0;
  exp_t cur;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_acc  = 0;
      prev_en = 0;
    end else begin
      if (dec_enable && !prev_en) begin
        if (q.size() == 0) begin
          chk("unexpected_access", 1, 0);
        end else begin
          cur = q.pop_front();
          chk("grant", int'(grant), 1 << cur.idx);
          if (cur.chk) chk("period", cyc - last_start, H + 2);
          last_start = cyc;
          in_acc = 1;
          en_len = 0;
        end
      end
      if (dec_enable && in_acc) begin
        en_len++;
        chk("dec_addr_stable", int'(dec_addr), cur.addr);
        chk("grant_held", int'(grant), 1 << cur.idx);
      end
      if (done != '0) begin
        if (in_acc) begin
          chk("done", int'(done), 1 << cur.idx);
          chk("enable_len", en_len, H);
          chk("busy_release", int'(busy), 1);
          chk("enable_release", int'(dec_enable), 0);
          in_acc = 0;
        end else begin
          chk("unexpected_done", int'(done), 0);
        end
      end
      prev_en = dec_enable;
    end
  end

  // Second-instance monitor: enable gaps and one-hot grant.
  int acc1 = 0, low_run = 0;
  bit seen1 = 0, prev_en1 = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen1    = 0;
      prev_en1 = 0;
      low_run  = 0;
    end else begin
      if (dec_enable1 && !prev_en1) begin
        if (seen1) chk("gap_ge2", int'(low_run >= 2), 1);
        seen1 = 1;
        acc1++;
      end
      low_run = dec_enable1 ? 0 : low_run + 1;
      chk("grant1_onehot0", int'($onehot0(grant1)), 1);
      prev_en1 = dec_enable1;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int c = 0;
    int t = 0;
    while (c < n && t < budget) begin
      @(negedge clk);
      t++;
      if (done != '0) c++;
    end
    if (c < n) chk("timeout_done", c, n);
  endtask

  task automatic wait_enable(input int budget);
    int t = 0;
    while (!dec_enable && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (!dec_enable) chk("timeout_enable", 0, 1);
  endtask

  initial begin
    int rr_idx[5];
    int c1, t1;
    rr_idx = '{0, 1, 2, 3, 0};
`ifndef DECODER_ARB_RR_EN
    rr_idx = '{0, 0, 0, 0, 0};
`endif

    #12;
    chk("rst_grant", int'(grant), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_enable", int'(dec_enable), 0);
    chk("rst_addr", int'(dec_addr), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single access from requester 2.
    req_addr[2*W +: W] = 9'd300;
    q.push_back('{2, 300, 0});
    req = 4'b0100;
    wait_dones(1, 20);
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    chk("single_busy_after", int'(busy), 0);
    chk("single_addr_after", int'(dec_addr), 0);

    // All four requesting, held.
    do_reset();
    for (int i = 0; i < N; i++) req_addr[i*W +: W] = W'(10 + i);
    for (int i = 0; i < 5; i++) q.push_back('{rr_idx[i], 10 + rr_idx[i], i > 0});
    req = 4'b1111;
    wait_dones(5, 40);
    @(posedge clk); #1 req = '0;
    repeat (3) @(negedge clk);

    // Address change and req drop during ACTIVE.
    do_reset();
    req_addr[1*W +: W] = 9'd5;
    q.push_back('{1, 5, 0});
    req = 4'b0010;
    wait_enable(10);
    req_addr[1*W +: W] = 9'd9;
    req[1] = 1'b0;
    wait_dones(1, 10);
    repeat (3) @(negedge clk);
    chk("drop_no_reaccess", int'(busy), 0);

    // Asynchronous reset in the second ACTIVE cycle.
    do_reset();
    req_addr[0*W +: W] = 9'd7;
    req_addr[1*W +: W] = 9'd8;
    q.push_back('{0, 7, 0});
    req = 4'b0011;
    wait_enable(10);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_grant", int'(grant), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_enable", int'(dec_enable), 0);
    chk("arst_addr", int'(dec_addr), 0);
    chk("arst_busy", int'(busy), 0);
    @(negedge clk);
    q.push_back('{0, 7, 0});
    rst_n = 1'b1;
    wait_dones(1, 10);
    @(posedge clk); #1 req = '0;
    repeat (3) @(negedge clk);

    // 50 back-to-back accesses on the HOLD_CYCLES=1 instance.
    req_addr1[0*W +: W] = 9'd100;
    req_addr1[1*W +: W] = 9'd200;
    req1 = 4'b0011;
    c1 = 0;
    t1 = 0;
    while (c1 < 50 && t1 < 400) begin
      @(negedge clk);
      t1++;
      if (done1 != '0) c1++;
    end
    if (c1 < 50) chk("timeout_gap", c1, 50);
    @(posedge clk); #1 req1 = '0;
    repeat (4) @(negedge clk);
    chk("gap_access_count", acc1, 50);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/decoder_arbiter.md
# decoder_arbiter

- Shares one `decoder` instance (one-hot cell select for the logic-circuit array) between `N_REQ` requesters.
- Arbitrates among pending requests and latches the winner's address onto the decoder's `binary_in` (`dec_addr`).
- Asserts the decoder's `enable` (`dec_enable`) for a fixed number of cycles.
- Guarantees a dead cycle between accesses so two decoder outputs are never active in adjacent cycles without a gap.
- Sits between configuration/evaluation agents (GA loader, readback, test port) and the decoder.

## Interface

- `IN_WIDTH`, 9, decoder address width; must match the decoder's `IN_WIDTH`.
- `N_REQ`, 4, number of requesters, 2..16.
- `HOLD_CYCLES`, 2, cycles `dec_enable` stays high per access, >= 1.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  request per requester; level, held until `done`.
- `req_addr`  in  N_REQ*IN_WIDTH  packed addresses; requester i at bits [i*IN_WIDTH +: IN_WIDTH].
- `grant`  out  N_REQ  one-hot; high for the whole ACTIVE phase of the served requester.
- `done`  out  N_REQ  one-hot, one-cycle pulse when the served access completes.
- `dec_enable`  out  1  to decoder `enable`.
- `dec_addr`  out  IN_WIDTH  to decoder `binary_in`.
- `busy`  out  1  high in ACTIVE and RELEASE.

## Operation

- All outputs are registered. States are IDLE, ACTIVE and RELEASE.
- **IDLE**
  - All outputs 0.
  - If `req` != 0: select winner w by the arbitration policy (see Configuration).
  - Latch `req_addr[w]` into `dec_addr`. Set `grant[w]` and `dec_enable`=1. Load hold counter with `HOLD_CYCLES-1`. Go to ACTIVE.
- **ACTIVE**
  - `dec_enable`, `grant[w]` and `dec_addr` are held constant.
  - Counter decrements each cycle. On 0: clear `dec_enable` and `grant`, pulse `done[w]`, go to RELEASE.
- **RELEASE**
  - One cycle. `busy`=1, `dec_enable`=0, `done[w]`=1, `dec_addr` keeps its last value.
  - Next state is IDLE, with `done` cleared and `dec_addr` cleared to 0.
- Hold counter width is $clog2(HOLD_CYCLES+1); it never wraps.
- Handshake rules:
  - A requester keeps `req` high from assertion until it samples `done`.
  - It deasserts `req` at the edge ending the `done` cycle.
  - `req` still high in the following IDLE is a new access.
- Boundary conditions:
  - `req[w]` dropped during ACTIVE: ignored; the access runs to completion and `done[w]` still pulses.
  - `req_addr[w]` changing after grant: ignored; the address is latched at grant.
  - Simultaneous requests: exactly one winner. Losers stay pending with no `grant` and no `done`.
  - `req` rising in ACTIVE/RELEASE: pending until the next IDLE evaluation.
  - Reset mid-access:
    - Outputs go to 0 immediately (async) and state goes to IDLE.
    - Round-robin pointer goes to N_REQ-1.
    - No `done` is issued for the aborted access.

## Timing

- Reset values:
  - `grant`, `done`, `dec_enable`, `dec_addr` and `busy` are all 0.
  - Pointer is N_REQ-1, so requester 0 has first priority.
- Grant latency: `req` sampled high in IDLE at edge k → `dec_enable`/`grant` high from edge k+1.
- `dec_enable` high for exactly `HOLD_CYCLES` cycles. `done` is high for the one cycle after that.
- Back-to-back accesses: period is `HOLD_CYCLES`+2 cycles (1 IDLE + `HOLD_CYCLES` ACTIVE + 1 RELEASE).
- `dec_enable` is low for at least 2 cycles between accesses.
- `dec_addr` is stable for the whole time `dec_enable` is high.

## Configuration

- `DECODER_ARB_RR_EN` defined: round-robin arbitration.
  - Search starts at (pointer+1) mod N_REQ.
  - Pointer updates to w on entry to RELEASE.
- `DECODER_ARB_RR_EN` undefined: fixed priority.
  - Lowest index with `req` high wins.
  - Pointer logic is not synthesized.

## Test plan

- **Reset/single access:** reset, release, `req`=4'b0100, `req_addr[2]`=9'd300, `HOLD_CYCLES`=2.
  - `dec_enable`=1 and `dec_addr`=300 for 2 cycles, then `done`=4'b0100 for 1 cycle, then `busy`=0.
- **Round-robin (RR_EN):** `req`=4'b1111 held and re-raised after each `done`.
  - Grants 0,1,2,3,0 in order, each 4 cycles apart.
- **Fixed priority (no RR_EN):** same stimulus.
  - Requester 0 wins every arbitration; requester 3 never granted while `req[0]` stays high.
- **Mid-access changes:** during ACTIVE, change `req_addr[1]` 5→9 and drop `req[1]`.
  - `dec_addr` stays 5 for the full hold; `done[1]` still pulses.
- **Reset mid-access:** assert `rst_n`=0 in the second ACTIVE cycle, asynchronously between edges.
  - All outputs 0 before the next edge; after release, requester 0 wins a tie with requester 1.
- **Gap check:** continuous `req`=4'b0011 for 50 accesses with `HOLD_CYCLES`=1.
  - `dec_enable` never high in two consecutive accesses without ≥2 low cycles between them.
  - `grant` is always one-hot or zero.
